pipelined_dot_product: RTL

Parametrised, fully pipelined N-tap weighted-sum (dot-product) engine with valid tagging, optional running accumulation and signed/unsigned arithmetic. It accepts one N-element data vector and one N-element weight vector per clock. It computes sum(i_data[k]*i_weights[k]) through a registered multiplier stage, a registered log2(N)-level adder tree and an output/accumulator register. It is the throughput-one successor to the fixed 4-tap cascaded summation pipeline, for use as the MAC core of filter and neural-layer datapaths.

---
 rtl/pipelined_dot_product.sv | 96 +++++++++
 1 files changed

// File: rtl/pipelined_dot_product.sv
// N-tap pipelined dot-product engine: registered multipliers, registered adder
// tree, and an output register that either overwrites or accumulates.
module pipelined_dot_product #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned N         = 4,
  parameter int unsigned SIGNED    = 0,
  parameter int unsigned OUT_WIDTH = 2 * WIDTH + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_acc,
  input  logic [WIDTH-1:0]     i_data    [0:N-1],
  input  logic [WIDTH-1:0]     i_weights [0:N-1],
  output logic                 o_valid,
  output logic [OUT_WIDTH-1:0] o_result
);

  localparam int unsigned L  = $clog2(N);
  localparam int unsigned PW = 2 * WIDTH;

  // Full-precision product; signedness follows the SIGNED parameter.
  function automatic logic [PW-1:0] mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
    sa = PW'($signed(a));
    sb = PW'($signed(b));
    if (SIGNED != 0) return PW'(sa * sb);
    else             return PW'(a) * PW'(b);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] ext(input logic [PW-1:0] p);
    if (SIGNED != 0) return OUT_WIDTH'($signed(p));
    else             return OUT_WIDTH'(p);
  endfunction

  logic [PW-1:0]        prod_q [N];
  logic [L:0]           vld_q;
  logic [L:0]           acc_q;
  logic [OUT_WIDTH-1:0] tree_sum;

  // Stage M
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N; k++) prod_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N; k++) prod_q[k] <= mul(i_data[k], i_weights[k]);
    end
  end

  // Level 0 is the extended product vector; each further level halves it.
  for (genvar g = 0; g <= int'(L); g++) begin : g_lvl
    localparam int unsigned CNT = N >> g;
    logic [OUT_WIDTH-1:0] node [CNT];
    if (g == 0) begin : g_leaf
      for (genvar k = 0; k < int'(N); k++) begin : g_ext
        assign node[k] = ext(prod_q[k]);
      end
    end else begin : g_add
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned j = 0; j < CNT; j++) node[j] <= '0;
        end else begin
          for (int unsigned j = 0; j < CNT; j++)
            node[j] <= g_lvl[g-1].node[2*j] + g_lvl[g-1].node[2*j+1];
        end
      end
    end
  end

  assign tree_sum = g_lvl[L].node[0];

  // Tags ride alongside the datapath: bit 0 is stage M, bit L the last tree level.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      acc_q <= '0;
    end else begin
      vld_q <= {vld_q[L-1:0], i_valid};
      acc_q <= {acc_q[L-1:0], i_acc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
    end else if (vld_q[L]) begin
      o_valid  <= 1'b1;
      o_result <= acc_q[L] ? o_result + tree_sum : tree_sum;
    end else begin
      o_valid  <= 1'b0;
    end
  end

endmodule
